verificador_sequencia_0_1_2_3_10_13: RTL and testbench
======================================================

// Module: verificador_sequencia_0_1_2_3_10_13
// PURPOSE
//  Downstream monitor for the 0,1,2,3,10,13 counter stage. Samples the counter's 4-bit output.
//  Locks onto the cyclic sequence and flags every out-of-order value with a one-cycle error pulse.
//  Counts completed sequences. Sits between the counter and the board status LEDs/display.
// PARAMETERS
//  CICLOS_W  8  width of the completed-cycle counter (saturating)
// PORTS
//  clock    in   1         single clock; all state updates on posedge
//  reset    in   1         synchronous, active-low; sampled on posedge clock; overrides all inputs
//  y_in     in   4         value from upstream counter
//  valid    in   1         y_in sampled only when 1; when 0 the cycle is ignored
//  ok       out  1         1 = monitor locked on sequence (state != BUSCA)
//  erro     out  1         one-cycle pulse: sampled value did not match expected
//  ciclos   out  CICLOS_W  number of complete 0..13 sequences seen, saturating
//  estado   out  3         current FSM state, debug visibility
// BEHAVIOUR
//  - Reset (reset==0 at posedge): estado=BUSCA, ok=0, erro=0, ciclos=0; wins over valid.
//  - All outputs registered; response appears the cycle after the sampled y_in.
//  - States: BUSCA, S0, S1, S2, S3, S10, S13. A state S_k means value k was the last accepted.
//  - Expected next value: S0->1, S1->2, S2->3, S3->10, S10->13, S13->0.
//  - valid==0: state, ok and ciclos hold; erro=0.
//  - BUSCA, valid==1: y_in==0 -> S0; any other value -> stay in BUSCA, no error (still hunting).
//  - S_k, valid==1, y_in==expected: advance to S_<y_in>; erro=0.
//  - S_k, valid==1, y_in!=expected: erro=1 for exactly that cycle.
//      If y_in==0, resync directly to S0 (ok stays 1). Otherwise go to BUSCA (ok=0).
//  - S10 with y_in==13: enter S13; ciclos+=1, saturating at 2**CICLOS_W-1 (no wrap).
//  - S13 with y_in==0: S0, normal wrap-around; not an error.
//  - Values 4..9, 11, 12, 14, 15 never match any expected value; they always error unless in BUSCA.
//  - ok = (next estado != BUSCA), registered together with estado.
//  - Reset asserted mid-sequence: next cycle is the reset state. No pulse is emitted; counters clear.
// CONFIGURATION
//  - `CONTADOR_ERROS_EN defined:
//      adds output n_erros [CICLOS_W-1:0], which counts erro pulses.
//      Saturating; reset to 0; increments in the same cycle erro is registered as 1.
//  - Undefined: port and register absent; all other behaviour identical.
// STRUCTURE
//  - Shared package seq_0_1_2_3_10_13_pkg holds:
//      state encodings BUSCA=0, S0..S13=1..6 (3 bits);
//      sequence values V0..V13 (4'd0,1,2,3,10,13);
//      function proximo_valor(state) returning the expected next value.
//  - The upstream counter also imports these values from the package.
//  - One sub-module: contador_saturante #(W), with inputs clock, reset, inc and output q.
//      Instantiated for ciclos, and again for n_erros when `CONTADOR_ERROS_EN is defined.
//  - FSM with next-state/output logic is kept in the top module.
// TESTING
//  1 Reset held low 2 cycles with valid=1, y_in=0 -> estado=BUSCA, ok=0, erro=0, ciclos=0.
//  2 Three full cycles of 0,1,2,3,10,13 with valid=1 -> ok=1 from the cycle after the first 0;
//    erro never set; ciclos=3.
//  3 Sequence 0,1,2,5 -> erro=1 exactly one cycle after the 5, then ok=0/BUSCA.
//    Then 7 -> no error (still BUSCA). Then 0 -> ok=1 again.
//  4 Sequence 0,1,2,0 -> erro pulse, estado=S0, ok stays 1.
//    Continuing 1,2,3,10,13 -> ciclos increments by 1.
//  5 Sequence 0,1 with valid=0 and y_in=9 for 3 cycles, then 2 -> no erro; estado=S2.
//  6 CICLOS_W=2, 5 complete cycles -> ciclos=3, held (no wrap).
//    Reset low during S3 -> next cycle all outputs at reset values.
//    With `CONTADOR_ERROS_EN: scenario 3 gives n_erros=1.

Source files
------------

// File: rtl/seq_0_1_2_3_10_13_pkg.sv
// Shared definitions for the 0,1,2,3,10,13 counter stage and its downstream monitor.
// State encodings, sequence values and the expected-next-value helper live here.
package seq_0_1_2_3_10_13_pkg;

    typedef enum logic [2:0] {
        BUSCA = 3'd0,
        S0    = 3'd1,
        S1    = 3'd2,
        S2    = 3'd3,
        S3    = 3'd4,
        S10   = 3'd5,
        S13   = 3'd6
    } estado_t;

    localparam logic [3:0] V0  = 4'd0;
    localparam logic [3:0] V1  = 4'd1;
    localparam logic [3:0] V2  = 4'd2;
    localparam logic [3:0] V3  = 4'd3;
    localparam logic [3:0] V10 = 4'd10;
    localparam logic [3:0] V13 = 4'd13;

    // Value the monitor expects after having accepted the value held by 'e'.
    function automatic logic [3:0] proximo_valor(input estado_t e);
        case (e)
            S0:      return V1;
            S1:      return V2;
            S2:      return V3;
            S3:      return V10;
            S10:     return V13;
            default: return V0;
        endcase
    endfunction

    // State that records 'v' as the last accepted value; BUSCA for off-sequence values.
    function automatic estado_t estado_de_valor(input logic [3:0] v);
        case (v)
            V0:      return S0;
            V1:      return S1;
            V2:      return S2;
            V3:      return S3;
            V10:     return S10;
            V13:     return S13;
            default: return BUSCA;
        endcase
    endfunction

endpackage

// File: rtl/contador_saturante.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// Synchronous active-low reset.
module contador_saturante #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/verificador_sequencia_0_1_2_3_10_13.sv
// Monitor that locks onto the 0,1,2,3,10,13 cycle, pulses erro on out-of-order values and
// counts completed cycles. Defining CONTADOR_ERROS_EN adds the saturating n_erros counter.
module verificador_sequencia_0_1_2_3_10_13
    import seq_0_1_2_3_10_13_pkg::*;
#(
    parameter int CICLOS_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          y_in,
    input  logic                valid,
    output logic                ok,
    output logic                erro,
    output logic [CICLOS_W-1:0] ciclos,
    output logic [2:0]          estado
`ifdef CONTADOR_ERROS_EN
    ,
    output logic [CICLOS_W-1:0] n_erros
`endif
);

    estado_t estado_q;
    estado_t estado_next;
    logic    erro_q;
    logic    erro_next;
    logic    fim_ciclo;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= BUSCA;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_next;
            erro_q   <= erro_next;
        end
    end

    // A mismatching 0 is treated as the start of a fresh cycle rather than a loss of lock.
    always_comb begin
        estado_next = estado_q;
        if (valid) begin
            if (estado_q == BUSCA) begin
                estado_next = (y_in == V0) ? S0 : BUSCA;
            end else if (y_in == proximo_valor(estado_q)) begin
                estado_next = estado_de_valor(y_in);
            end else begin
                estado_next = (y_in == V0) ? S0 : BUSCA;
            end
        end
    end

    always_comb begin
        erro_next = valid && (estado_q != BUSCA) && (y_in != proximo_valor(estado_q));
        fim_ciclo = valid && (estado_q == S10) && (y_in == V13);
        ok        = (estado_q != BUSCA);
        erro      = erro_q;
        estado    = estado_q;
    end

    contador_saturante #(.W(CICLOS_W)) u_ciclos (
        .clock (clock),
        .reset (reset),
        .inc   (fim_ciclo),
        .q     (ciclos)
    );

`ifdef CONTADOR_ERROS_EN
    contador_saturante #(.W(CICLOS_W)) u_n_erros (
        .clock (clock),
        .reset (reset),
        .inc   (erro_next),
        .q     (n_erros)
    );
`endif

endmodule

// File: tb/tb_verificador_sequencia_0_1_2_3_10_13.sv
// Bench for the 0,1,2,3,10,13 sequence monitor: a wide and a 2-bit-counter instance share
// the same stimulus and are checked against a sequence-position reference model.
module tb_verificador_sequencia_0_1_2_3_10_13;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] y_in  = 4'd0;

    logic       ok_a, erro_a, ok_b, erro_b;
    logic [7:0] ciclos_a;
    logic [1:0] ciclos_b;
    logic [2:0] estado_a, estado_b;
`ifdef CONTADOR_ERROS_EN
    logic [7:0] n_erros_a;
    logic [1:0] n_erros_b;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the cycle (-1 while hunting for a 0).
    int         seq_v[6] = '{0, 1, 2, 3, 10, 13};
    int         pos   = -1;
    int         cyc   = 0;
    int         nerr  = 0;
    logic       err_m = 1'b0;
    logic [2:0] exp_q[$];

    always #5 clock = ~clock;

    verificador_sequencia_0_1_2_3_10_13 #(.CICLOS_W(8)) dut_a (
        .clock   (clock),
        .reset   (reset),
        .y_in    (y_in),
        .valid   (valid),
        .ok      (ok_a),
        .erro    (erro_a),
        .ciclos  (ciclos_a),
        .estado  (estado_a)
`ifdef CONTADOR_ERROS_EN
        ,
        .n_erros (n_erros_a)
`endif
    );

    verificador_sequencia_0_1_2_3_10_13 #(.CICLOS_W(2)) dut_b (
        .clock   (clock),
        .reset   (reset),
        .y_in    (y_in),
        .valid   (valid),
        .ok      (ok_b),
        .erro    (erro_b),
        .ciclos  (ciclos_b),
        .estado  (estado_b)
`ifdef CONTADOR_ERROS_EN
        ,
        .n_erros (n_erros_b)
`endif
    );

    function automatic int sat(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    function automatic int proximo_esperado();
        return (pos < 0) ? 0 : seq_v[(pos + 1) % 6];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic rst_n, input logic v, input int y);
        err_m = 1'b0;
        if (!rst_n) begin
            pos  = -1;
            cyc  = 0;
            nerr = 0;
        end else if (v) begin
            if (pos < 0) begin
                if (y == 0) pos = 0;
            end else if (y == seq_v[(pos + 1) % 6]) begin
                pos = (pos + 1) % 6;
                if (pos == 5) cyc++;
            end else begin
                err_m = 1'b1;
                nerr++;
                pos = (y == 0) ? 0 : -1;
            end
        end
        exp_q.push_back((pos < 0) ? 3'd0 : 3'(pos + 1));
    endtask

    task automatic step(input logic rst_n, input logic v, input int y);
        logic [2:0] e;
        reset = rst_n;
        valid = v;
        y_in  = 4'(y);
        @(posedge clock);
        model(rst_n, v, y);
        #1;
        e = exp_q.pop_front();
        chk("estado_a", estado_a, e);
        chk("estado_b", estado_b, e);
        chk("ok_a", ok_a, pos >= 0);
        chk("ok_b", ok_b, pos >= 0);
        chk("erro_a", erro_a, err_m);
        chk("erro_b", erro_b, err_m);
        chk("ciclos_a", ciclos_a, sat(cyc, 8));
        chk("ciclos_b", ciclos_b, sat(cyc, 2));
`ifdef CONTADOR_ERROS_EN
        chk("n_erros_a", n_erros_a, sat(nerr, 8));
        chk("n_erros_b", n_erros_b, sat(nerr, 2));
`endif
    endtask

    task automatic ciclos_completos(input int n);
        for (int c = 0; c < n; c++)
            for (int k = 0; k < 6; k++) step(1'b1, 1'b1, seq_v[k]);
    endtask

    initial begin
        // Reset held with valid high and a 0 on the bus
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        chk("rst_estado", estado_a, 3'd0);
        chk("rst_ok", ok_a, 1'b0);
        chk("rst_erro", erro_a, 1'b0);
        chk("rst_ciclos", ciclos_a, 8'd0);

        ciclos_completos(3);
        chk("cen2_ciclos", ciclos_a, 8'd3);
        chk("cen2_ok", ok_a, 1'b1);

        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 5);
        chk("cen3_erro", erro_a, 1'b1);
        chk("cen3_ok", ok_a, 1'b0);
`ifdef CONTADOR_ERROS_EN
        chk("cen3_n_erros", n_erros_a, 8'd1);
`endif
        step(1'b1, 1'b1, 7);
        chk("cen3_sem_erro", erro_a, 1'b0);
        step(1'b1, 1'b1, 0);
        chk("cen3_relock", ok_a, 1'b1);

        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 0);
        chk("cen4_erro", erro_a, 1'b1);
        chk("cen4_estado", estado_a, 3'd1);
        chk("cen4_ok", ok_a, 1'b1);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b1, 13);
        chk("cen4_ciclos", ciclos_a, 8'd4);

        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        repeat (3) step(1'b1, 1'b0, 9);
        step(1'b1, 1'b1, 2);
        chk("cen5_erro", erro_a, 1'b0);
        chk("cen5_estado", estado_a, 3'd3);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b1, 13);

        ciclos_completos(5);
        chk("cen6_sat_b", ciclos_b, 2'd3);
        chk("cen6_ciclos_a", ciclos_a, 8'd10);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 10);
        chk("cen6_rst_estado", estado_a, 3'd0);
        chk("cen6_rst_ciclos", ciclos_a, 8'd0);

        // Randomised traffic, biased towards the legal continuation
        for (int i = 0; i < 800; i++) begin
            logic r, v;
            int   y;
            r = ($urandom_range(0, 49) != 0);
            v = ($urandom_range(0, 9) < 8);
            y = ($urandom_range(0, 9) < 7) ? proximo_esperado() : int'($urandom_range(0, 15));
            step(r, v, y);
        end

        // Wide counter must stop at its maximum
        step(1'b0, 1'b0, 0);
        ciclos_completos(257);
        chk("sat_ciclos_a", ciclos_a, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
